// File: rtl/dkey_expand_if.sv
// Interface bundle for the AES-128 decryption key schedule.
// The master side is the round controller, which requests expansion and reads round keys.
interface dkey_expand_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rd_idx;
  logic [127:0] rkey;

  modport master (
    output start, key_in, rd_idx,
    input  busy, done, keys_valid, rkey
  );

  modport slave (
    input  start, key_in, rd_idx,
    output busy, done, keys_valid, rkey
  );
endinterface

// File: rtl/dkey_expand.sv
// AES-128 key expansion into an 11-entry round-key bank, one key per clock.
// The decryption round controller reads keys by index, with a registered read.
module dkey_expand #(
  parameter int NR = 10
) (
  input  logic          clk,
  input  logic          rst,
  dkey_expand_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic [127:0] rkey_q, rkey_d;
  logic [127:0] bank_q [NR+1];
  logic [127:0] bank_d [NR+1];

  logic         wr_en;
  logic [3:0]   wr_idx;
  logic [127:0] wr_data;
  logic [3:0]   prev_idx;
  logic [127:0] prev_key;
  logic [31:0]  rot_word, sub_word, t_word;
  logic [31:0]  o0, o1, o2, o3;
  logic [7:0]   rcon;

  // The previous key always comes from the bank, so the whole schedule is one shared round function.
  assign prev_idx = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
  assign prev_key = bank_q[prev_idx];
  assign rot_word = {prev_key[23:0], prev_key[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sbox
      assign sub_word[gi*8 +: 8] = SBOX[rot_word[gi*8 +: 8]];
    end
  endgenerate

  always_comb begin
    rcon = 8'h00;
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign t_word = sub_word ^ {rcon, 24'h0};
  assign o0     = prev_key[127:96] ^ t_word;
  assign o1     = prev_key[95:64]  ^ o0;
  assign o2     = prev_key[63:32]  ^ o1;
  assign o3     = prev_key[31:0]   ^ o2;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    wr_en   = 1'b0;
    wr_idx  = cnt_q;
    wr_data = {o0, o1, o2, o3};
    case (state_q)
      IDLE, READY: begin
        if (bus.start) begin
          wr_en   = 1'b1;
          wr_idx  = 4'd0;
          wr_data = bus.key_in;
          cnt_d   = 4'd1;
          state_d = EXPAND;
        end
      end
      EXPAND: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) begin
          state_d = READY;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bank_d = bank_q;
    if (wr_en) bank_d[wr_idx] = wr_data;
  end

  // Read samples the bank before this edge's write, so a same-edge write returns the old key.
  assign rkey_d = (bus.rd_idx <= 4'(NR)) ? bank_q[bus.rd_idx] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
      rkey_q  <= '0;
      for (int i = 0; i < NR + 1; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      rkey_q  <= rkey_d;
      bank_q  <= bank_d;
    end
  end

  assign bus.busy       = (state_q == EXPAND);
  assign bus.keys_valid = (state_q == READY);
  assign bus.done       = done_q;
  assign bus.rkey       = rkey_q;
endmodule

// File: tb/tb_dkey_expand.sv
// Directed bench for dkey_expand using the FIPS-197 key-expansion vectors.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
module tb_dkey_expand;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  dkey_expand_if bus ();

  dkey_expand #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [127:0] fips_keys [11] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic read_key(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    bus.rd_idx = idx;
    tick();
    check_eq($sformatf("%s_rd%0d", tag, idx), bus.rkey, exp);
  endtask

  // One full expansion: a start pulse, then 10 edges with done checked at every one.
  // A nonzero restart_at drives a second start pulse at that edge of the expansion.
  task automatic expand(input logic [127:0] key, input int restart_at, input string tag);
    bus.key_in = key;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    check_eq({tag, "_busy_on"}, 128'(bus.busy), 128'd1);
    check_eq({tag, "_kv_drop"}, 128'(bus.keys_valid), 128'd0);
    for (int k = 1; k <= 10; k++) begin
      bus.start = (k == restart_at);
      tick();
      check_eq($sformatf("%s_done_e%0d", tag, k), 128'(bus.done), 128'(k == 10));
    end
    bus.start = 1'b0;
    check_eq({tag, "_busy_off"}, 128'(bus.busy), 128'd0);
    check_eq({tag, "_kv_set"}, 128'(bus.keys_valid), 128'd1);
    tick();
    check_eq({tag, "_done_clr"}, 128'(bus.done), 128'd0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.key_in = '0;
    bus.rd_idx = 4'd0;

    // Reset state and an all-zero bank.
    rst = 1'b1;
    tick();
    tick();
    check_eq("rst_busy", 128'(bus.busy), 128'd0);
    check_eq("rst_done", 128'(bus.done), 128'd0);
    check_eq("rst_kv", 128'(bus.keys_valid), 128'd0);
    check_eq("rst_rkey", bus.rkey, 128'd0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) read_key(4'(i), 128'd0, "rst");

    // FIPS-197 cipher key.
    expand(fips_keys[0], 0, "fips");
    read_key(4'd0, fips_keys[0], "fips");
    read_key(4'd1, fips_keys[1], "fips");
    read_key(4'd10, fips_keys[10], "fips");

    // Back-to-back sweep 10 down to 0: each key one cycle after its index.
    bus.rd_idx = 4'd10;
    for (int i = 10; i >= 0; i--) begin
      tick();
      bus.rd_idx = (i > 0) ? 4'(i - 1) : 4'd11;
      check_eq($sformatf("sweep_rd%0d", i), bus.rkey, fips_keys[i]);
    end
    tick();
    check_eq("sweep_rd11", bus.rkey, 128'd0);

    // Rekey from READY with a stray start 3 cycles in; it must not restart.
    expand(fips_keys[0], 3, "restart");
    read_key(4'd10, fips_keys[10], "restart");

    // Abort at cycle 5 of an expansion with reset; no done and no valid flag may follow.
    bus.key_in = 128'h00112233445566778899aabbccddeeff;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq($sformatf("abort_done_e%0d", k), 128'(bus.done), 128'd0);
    end
    rst        = 1'b1;
    bus.rd_idx = 4'd0;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", 128'(bus.busy), 128'd0);
    check_eq("abort_kv", 128'(bus.keys_valid), 128'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq($sformatf("abort_quiet%0d", k), 128'(bus.done | bus.keys_valid), 128'd0);
    end
    read_key(4'd0, 128'd0, "abort");
    read_key(4'd1, 128'd0, "abort");
    expand(128'h000102030405060708090a0b0c0d0e0f, 0, "seq");
    read_key(4'd10, 128'h13111d7fe3944a17f307a78b4d2b30c5, "seq");

    // Rekey from READY with the all-zero key.
    expand(128'd0, 0, "zero");
    read_key(4'd1, 128'h62636363626363636263636362636363, "zero");
    read_key(4'd0, 128'd0, "zero");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
